// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter and its per-client ports.
package mem_arbiter_pkg;

   localparam int OFFSET_BITS = 5;
   localparam int LINE_OFFSET = OFFSET_BITS;
   localparam int ADDR_W      = 32;
   localparam int LINE_W      = 256;
   localparam int TAG_W       = ADDR_W - LINE_OFFSET;

   typedef enum logic [1:0] {
      IDLE,
      PEND,
      DONE,
      WDONE
   } port_state_t;

   typedef enum logic {
      ICACHE,
      DCACHE
   } client_e;

   // Clear the byte offset so the adapter always sees a line-aligned address.
   function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:LINE_OFFSET], {LINE_OFFSET{1'b0}}};
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache miss ports, the arbiter and the cacheline adapter.
// The master view belongs to the arbiter; the slave view is the surrounding system.
interface mem_arbiter_if;
   import mem_arbiter_pkg::*;

   logic [ADDR_W-1:0] icache_addr;
   logic              icache_read;
   logic [LINE_W-1:0] icache_rdata;
   logic              icache_resp;

   logic [ADDR_W-1:0] dcache_addr;
   logic              dcache_read;
   logic              dcache_write;
   logic [LINE_W-1:0] dcache_wdata;
   logic [LINE_W-1:0] dcache_rdata;
   logic              dcache_resp;

   logic [ADDR_W-1:0] mc_addr;
   logic              mc_read;
   logic              mc_write;
   logic [LINE_W-1:0] mc_wdata;

   logic              cl_ready;
   logic [ADDR_W-1:0] cl_raddr;
   logic [LINE_W-1:0] cl_rdata;
   logic              cl_resp;

   logic              spurious_resp;

   modport master (
      input  icache_addr, icache_read,
      output icache_rdata, icache_resp,
      input  dcache_addr, dcache_read, dcache_write, dcache_wdata,
      output dcache_rdata, dcache_resp,
      output mc_addr, mc_read, mc_write, mc_wdata,
      input  cl_ready, cl_raddr, cl_rdata, cl_resp,
      output spurious_resp
   );

   modport slave (
      output icache_addr, icache_read,
      input  icache_rdata, icache_resp,
      output dcache_addr, dcache_read, dcache_write, dcache_wdata,
      input  dcache_rdata, dcache_resp,
      input  mc_addr, mc_read, mc_write, mc_wdata,
      output cl_ready, cl_raddr, cl_rdata, cl_resp,
      input  spurious_resp
   );

endinterface

// File: rtl/mem_arb_port.sv
// Per-client tracking: request state, pending line tag, relative age and returned line.
module mem_arb_port
   import mem_arbiter_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             read_i,
   input  logic             write_i,
   input  logic [TAG_W-1:0] tag_i,
   input  logic             grant_i,
   input  logic             other_grant_i,
   input  logic [TAG_W-1:0] cl_rtag_i,
   input  logic [LINE_W-1:0] cl_rdata_i,
   input  logic             hit_i,
   output logic             eligible_o,
   output logic             match_o,
   output logic             young_o,
   output logic             resp_o,
   output logic [LINE_W-1:0] rdata_o
);

   port_state_t       state_q;
   logic [TAG_W-1:0]  tag_q;
   logic              young_q;
   logic [LINE_W-1:0] rdata_q;

   // Client FSM plus the line tag, age flag and response data it owns.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         tag_q   <= '0;
         young_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         // The most recent issue is the younger one; the other client becomes older.
         if (grant_i) begin
            young_q <= 1'b1;
         end else if (other_grant_i) begin
            young_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (grant_i) begin
                  tag_q   <= tag_i;
                  state_q <= write_i ? WDONE : PEND;
               end
            end
            PEND: begin
               if (hit_i) begin
                  rdata_q <= cl_rdata_i;
                  state_q <= DONE;
               end
            end
            DONE, WDONE: state_q <= IDLE;
            default:     state_q <= IDLE;
         endcase
      end
   end

   assign eligible_o = (state_q == IDLE) && (read_i || write_i);
   assign match_o    = (state_q == PEND) && (tag_q == cl_rtag_i);
   assign young_o    = young_q;
   assign resp_o     = (state_q == DONE) || (state_q == WDONE);
   assign rdata_o    = rdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter of I-cache and D-cache line traffic onto one adapter port,
// with out-of-order response routing by line address.
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.master bus
);

   logic    i_elig, d_elig;
   logic    i_match, d_match;
   logic    i_young, d_young;
   logic    i_hit, d_hit;
   logic    gnt_i, gnt_d;
   client_e last_q;
   logic    spur_q;
   logic    unused_offset;

   assign unused_offset = ^bus.cl_raddr[LINE_OFFSET-1:0];

   mem_arb_port u_iport (
      .clk           (clk),
      .rst           (rst),
      .read_i        (bus.icache_read),
      .write_i       (1'b0),
      .tag_i         (bus.icache_addr[ADDR_W-1:LINE_OFFSET]),
      .grant_i       (gnt_i),
      .other_grant_i (gnt_d),
      .cl_rtag_i     (bus.cl_raddr[ADDR_W-1:LINE_OFFSET]),
      .cl_rdata_i    (bus.cl_rdata),
      .hit_i         (i_hit),
      .eligible_o    (i_elig),
      .match_o       (i_match),
      .young_o       (i_young),
      .resp_o        (bus.icache_resp),
      .rdata_o       (bus.icache_rdata)
   );

   mem_arb_port u_dport (
      .clk           (clk),
      .rst           (rst),
      .read_i        (bus.dcache_read),
      .write_i       (bus.dcache_write),
      .tag_i         (bus.dcache_addr[ADDR_W-1:LINE_OFFSET]),
      .grant_i       (gnt_d),
      .other_grant_i (gnt_i),
      .cl_rtag_i     (bus.cl_raddr[ADDR_W-1:LINE_OFFSET]),
      .cl_rdata_i    (bus.cl_rdata),
      .hit_i         (d_hit),
      .eligible_o    (d_elig),
      .match_o       (d_match),
      .young_o       (d_young),
      .resp_o        (bus.dcache_resp),
      .rdata_o       (bus.dcache_rdata)
   );

   // Grant selection; held at zero during reset so no issue leaks out while state clears.
   always_comb begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
      if (rst && bus.cl_ready) begin
         if (i_elig && d_elig) begin
            if (last_q == ICACHE) begin
               gnt_d = 1'b1;
            end else begin
               gnt_i = 1'b1;
            end
         end else begin
            gnt_i = i_elig;
            gnt_d = d_elig;
         end
      end
   end

   // Remember the last winner so a conflict alternates between clients.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_q <= ICACHE;
      end else if (gnt_i) begin
         last_q <= ICACHE;
      end else if (gnt_d) begin
         last_q <= DCACHE;
      end
   end

   // Issue mux onto the adapter request port; unissued fields are driven to zero.
   always_comb begin
      bus.mc_read  = 1'b0;
      bus.mc_write = 1'b0;
      bus.mc_addr  = '0;
      bus.mc_wdata = '0;
      if (gnt_i) begin
         bus.mc_read = 1'b1;
         bus.mc_addr = line_align(bus.icache_addr);
      end else if (gnt_d) begin
         bus.mc_addr = line_align(bus.dcache_addr);
         if (bus.dcache_write) begin
            bus.mc_write = 1'b1;
            bus.mc_wdata = bus.dcache_wdata;
         end else begin
            bus.mc_read = 1'b1;
         end
      end
   end

   // When both clients wait on the same line, only the older issue takes this response.
   assign i_hit = bus.cl_resp && i_match && (!d_match || d_young);
   assign d_hit = bus.cl_resp && d_match && (!i_match || i_young);

   // Flag a returning line that no pending read claimed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         spur_q <= 1'b0;
      end else begin
         spur_q <= bus.cl_resp && !i_match && !d_match;
      end
   end

   assign bus.spurious_resp = spur_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter plus hand-written reset sequences.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   typedef struct {
      logic        ir;
      logic [31:0] ia;
      logic        dr;
      logic        dw;
      logic [31:0] da;
      logic [31:0] wd;
      logic        rdy;
      logic        clr;
      logic [31:0] cra;
      logic [31:0] crd;
      logic        emr;
      logic        emw;
      logic [31:0] ema;
      logic [31:0] ewd;
      logic        eir;
      logic [31:0] eird;
      logic        edr;
      logic        edchk;
      logic [31:0] edrd;
      logic        esp;
   } vec_t;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   vec_t vq[$];

   mem_arbiter_if bus();

   mem_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [255:0] rep(input logic [31:0] s);
      return {8{s}};
   endfunction

   task automatic check(input string nm, input int step, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h expected %h", nm, step, act, exp);
      end
   endtask

   task automatic add(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [31:0] da, input logic [31:0] wd, input logic rdy, input logic clr,
                      input logic [31:0] cra, input logic [31:0] crd, input logic emr, input logic emw,
                      input logic [31:0] ema, input logic [31:0] ewd, input logic eir, input logic [31:0] eird,
                      input logic edr, input logic edchk, input logic [31:0] edrd, input logic esp);
      vec_t v;
      v.ir = ir;   v.ia = ia;   v.dr = dr;   v.dw = dw;   v.da = da;   v.wd = wd;
      v.rdy = rdy; v.clr = clr; v.cra = cra; v.crd = crd;
      v.emr = emr; v.emw = emw; v.ema = ema; v.ewd = ewd;
      v.eir = eir; v.eird = eird; v.edr = edr; v.edchk = edchk; v.edrd = edrd; v.esp = esp;
      vq.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      bus.icache_read  = v.ir;
      bus.icache_addr  = v.ia;
      bus.dcache_read  = v.dr;
      bus.dcache_write = v.dw;
      bus.dcache_addr  = v.da;
      bus.dcache_wdata = rep(v.wd);
      bus.cl_ready     = v.rdy;
      bus.cl_resp      = v.clr;
      bus.cl_raddr     = v.cra;
      bus.cl_rdata     = rep(v.crd);
   endtask

   task automatic check_vec(input vec_t v, input int step);
      check("mc_read",  step, {255'd0, bus.mc_read},  {255'd0, v.emr});
      check("mc_write", step, {255'd0, bus.mc_write}, {255'd0, v.emw});
      check("mc_addr",  step, {224'd0, bus.mc_addr},  {224'd0, v.ema});
      check("mc_wdata", step, bus.mc_wdata, (v.emw ? rep(v.ewd) : 256'd0));
      check("icache_resp", step, {255'd0, bus.icache_resp}, {255'd0, v.eir});
      if (v.eir) check("icache_rdata", step, bus.icache_rdata, rep(v.eird));
      check("dcache_resp", step, {255'd0, bus.dcache_resp}, {255'd0, v.edr});
      if (v.edchk) check("dcache_rdata", step, bus.dcache_rdata, rep(v.edrd));
      check("spurious_resp", step, {255'd0, bus.spurious_resp}, {255'd0, v.esp});
   endtask

   task automatic check_quiet(input string nm, input int step);
      check({nm, "_mc_read"},  step, {255'd0, bus.mc_read},       256'd0);
      check({nm, "_mc_write"}, step, {255'd0, bus.mc_write},      256'd0);
      check({nm, "_mc_addr"},  step, {224'd0, bus.mc_addr},       256'd0);
      check({nm, "_iresp"},    step, {255'd0, bus.icache_resp},   256'd0);
      check({nm, "_dresp"},    step, {255'd0, bus.dcache_resp},   256'd0);
      check({nm, "_spur"},     step, {255'd0, bus.spurious_resp}, 256'd0);
   endtask

   initial begin
      vec_t z;
      n_tests = 0;
      n_fail  = 0;

      // Both clients read in the same cycle out of reset: D wins, I follows; responses reversed.
      add(1,'h100, 1,0,'h200,0, 1, 0,0,0,           1,0,'h200,0, 0,0,       0,0,0,       0);
      add(1,'h100, 1,0,'h200,0, 1, 0,0,0,           1,0,'h100,0, 0,0,       0,0,0,       0);
      add(1,'h100, 1,0,'h200,0, 1, 1,'h100,'h1111,  0,0,0,0,     0,0,       0,0,0,       0);
      add(0,0,     1,0,'h200,0, 1, 1,'h200,'h2222,  0,0,0,0,     1,'h1111,  0,0,0,       0);
      add(0,0,     0,0,0,0,     1, 0,0,0,           0,0,0,0,     0,0,       1,1,'h2222,  0);
      // Single I-cache read with unaligned address.
      add(1,'h1234, 0,0,0,0,    1, 0,0,0,           1,0,'h1220,0, 0,0,      0,0,0,       0);
      add(1,'h1234, 0,0,0,0,    1, 0,0,0,           0,0,0,0,     0,0,       0,0,0,       0);
      add(1,'h1234, 0,0,0,0,    1, 1,'h1220,'hAAAA, 0,0,0,0,     0,0,       0,0,0,       0);
      add(0,0,      0,0,0,0,    1, 0,0,0,           0,0,0,0,     1,'hAAAA,  0,0,0,       0);
      // Posted write-back, then adapter busy for three cycles holding off an I read.
      add(0,0, 0,1,'h300,'h3333, 1, 0,0,0,          0,1,'h300,'h3333, 0,0,  0,0,0,       0);
      add(1,'h500, 0,0,0,0,      0, 0,0,0,          0,0,0,0,     0,0,       1,0,0,       0);
      add(1,'h500, 0,0,0,0,      0, 0,0,0,          0,0,0,0,     0,0,       0,0,0,       0);
      add(1,'h500, 0,0,0,0,      0, 0,0,0,          0,0,0,0,     0,0,       0,0,0,       0);
      add(1,'h500, 0,0,0,0,      1, 0,0,0,          1,0,'h500,0, 0,0,       0,0,0,       0);
      add(1,'h500, 0,0,0,0,      1, 1,'h500,'h5555, 0,0,0,0,     0,0,       0,0,0,       0);
      add(0,0,     0,0,0,0,      1, 0,0,0,          0,0,0,0,     1,'h5555,  0,0,0,       0);
      // Same line pending for both clients: the older (I) gets the first response.
      add(1,'h400, 0,0,0,0,      1, 0,0,0,          1,0,'h400,0, 0,0,       0,0,0,       0);
      add(1,'h400, 1,0,'h404,0,  1, 0,0,0,          1,0,'h400,0, 0,0,       0,0,0,       0);
      add(1,'h400, 1,0,'h404,0,  1, 1,'h41F,'h6666, 0,0,0,0,     0,0,       0,0,0,       0);
      add(0,0,     1,0,'h404,0,  1, 1,'h400,'h7777, 0,0,0,0,     1,'h6666,  0,0,0,       0);
      add(0,0,     0,0,0,0,      1, 0,0,0,          0,0,0,0,     0,0,       1,1,'h7777,  0);
      // Unmatched response.
      add(0,0,     0,0,0,0,      1, 1,'h999,'h9999, 0,0,0,0,     0,0,       0,0,0,       0);
      add(0,0,     0,0,0,0,      1, 0,0,0,          0,0,0,0,     0,0,       0,0,0,       1);
      add(0,0,     0,0,0,0,      1, 0,0,0,          0,0,0,0,     0,0,       0,0,0,       0);

      // Reset with requests pending and adapter ready: nothing may issue or respond.
      rst = 1'b0;
      z = '{default: '0};
      z.ir = 1'b1; z.ia = 32'h100; z.dr = 1'b1; z.da = 32'h200; z.rdy = 1'b1;
      drive(z);
      @(negedge clk);
      #4;
      check_quiet("reset", 0);

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         rst = 1'b1;
         drive(vq[i]);
         #4;
         check_vec(vq[i], i);
      end

      // Reset while I is pending; the late line must come back unmatched.
      z = '{default: '0};
      z.ir = 1'b1; z.ia = 32'h800; z.rdy = 1'b1;
      @(negedge clk);
      drive(z);
      #4;
      check("rst_issue_mc_read", 100, {255'd0, bus.mc_read}, 256'd1);
      check("rst_issue_mc_addr", 100, {224'd0, bus.mc_addr}, {224'd0, 32'h800});
      @(negedge clk);
      z.dr = 1'b1; z.da = 32'h200;
      drive(z);
      rst = 1'b0;
      #1;
      check_quiet("midreset", 101);
      @(negedge clk);
      #4;
      check_quiet("midreset_hold", 102);
      @(negedge clk);
      rst = 1'b1;
      z = '{default: '0};
      z.rdy = 1'b1; z.clr = 1'b1; z.cra = 32'h800; z.crd = 32'hBEEF;
      drive(z);
      #4;
      check_quiet("late_resp", 103);
      @(negedge clk);
      z.clr = 1'b0;
      drive(z);
      #4;
      check("late_spur",  104, {255'd0, bus.spurious_resp}, 256'd1);
      check("late_iresp", 104, {255'd0, bus.icache_resp},   256'd0);
      @(negedge clk);
      #4;
      check_quiet("after_late", 105);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Memory arbiter between the I-cache/D-cache miss ports and the cacheline adapter. It round-robins line reads and write-backs onto the adapter's single request port, issuing only when the adapter is ready. It tracks one outstanding read per client and routes out-of-order line responses back by line address. Write-backs are posted.

## Interface
- OFFSET_BITS, 5: line offset width (32-byte lines); request addresses are forced line-aligned.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- icache_addr  in  32  I-cache miss address.
- icache_read  in  1  I-cache read request; held until icache_resp.
- icache_rdata  out  256  line returned to the I-cache.
- icache_resp  out  1  one-cycle pulse; icache_rdata valid.
- dcache_addr  in  32  D-cache miss or write-back address.
- dcache_read  in  1  D-cache read request; held until dcache_resp.
- dcache_write  in  1  D-cache write-back request; held until dcache_resp; never asserted together with dcache_read.
- dcache_wdata  in  256  write-back line.
- dcache_rdata  out  256  line returned to the D-cache.
- dcache_resp  out  1  one-cycle pulse, for a read or write completion.
- mc_addr  out  32  line-aligned address to the adapter.
- mc_read  out  1  read issue; asserted only when cl_ready=1.
- mc_write  out  1  write issue; asserted only when cl_ready=1.
- mc_wdata  out  256  write line, equal to dcache_wdata in the issue cycle.
- cl_ready  in  1  adapter can accept an issue this cycle.
- cl_raddr  in  32  address of the returning line.
- cl_rdata  in  256  returning line.
- cl_resp  in  1  one-cycle pulse; returning line valid.
- spurious_resp  out  1  one-cycle pulse; cl_resp matched no pending read.

## Operation
- Per-client states:
  - IDLE: no request in flight.
  - PEND: read issued, awaiting response.
  - DONE: response pulse cycle.
  - The D-cache port also has WDONE: write issued, resp pulse.
- Eligibility: a client is eligible when it is in IDLE with its request asserted. A held request in PEND, DONE or WDONE is never reissued.
- Issue: when cl_ready=1 and at least one client is eligible, grant one client.
  - Both eligible: grant the client not granted last (round-robin). last_grant resets to I-cache, so the first conflict goes to the D-cache.
  - Granted read: mc_read=1, mc_addr={addr[31:5],5'b0}; the client moves IDLE->PEND and records its line address and an age stamp.
  - Granted write: mc_write=1, mc_wdata=dcache_wdata; the D-cache moves IDLE->WDONE.
  - mc_read and mc_write are never both 1. All mc_* issue outputs are combinational from the current state and cl_ready.
- Response matching: on cl_resp, compare cl_raddr[31:5] against the line address of each client in PEND.
  - One match: latch cl_rdata into that client's rdata register; the client moves PEND->DONE.
  - Two matches (same line pending for both): route to the older issue only. The other stays PEND for the next response to that line.
  - No match: pulse spurious_resp next cycle; the line is dropped.
- DONE/WDONE -> IDLE after one cycle with resp=1. The client drops its request in that same cycle, so it is not re-sampled as eligible until the following cycle.
- Issue and response may occur in the same cycle, for the same or different clients.

## Timing
- Reset values: all resp=0, mc_read=0, mc_write=0, spurious_resp=0, all states IDLE.
  - rdata registers and mc_addr/mc_wdata with no issue are don't-care; drive 0.
- Issue latency: a request asserted in cycle T with cl_ready=1 and no conflict issues in T (combinational grant).
- Read completion: cl_resp in cycle R gives client resp=1 with the line in R+1.
- Write completion: issue in cycle T gives dcache_resp=1 in T+1. The adapter then drops cl_ready for the remaining burst beats, which holds off further issues.
- Reset mid-operation: all state clears immediately. Responses for reads issued before reset arrive unmatched and raise spurious_resp; no client resp is generated.

## Structure
- The params package holds:
  - port_state_t enum (IDLE, PEND, DONE, WDONE);
  - client_e enum (ICACHE, DCACHE);
  - LINE_OFFSET constant.
- Sub-module mem_arb_port, instantiated once per client. It contains the state register, line address, age bit and rdata register, and produces eligible/match signals.
- The top level holds the round-robin grant, issue mux and response routing. Estimated size is about 200 lines.

## Test plan
- I-cache read of 0x0000_1234 with cl_ready=1 -> mc_read=1 and mc_addr=0x0000_1220 the same cycle. cl_resp with raddr 0x0000_1220 and data D -> icache_resp=1 and icache_rdata=D one cycle later.
- Both clients read (I 0x100, D 0x200) in the same cycle from reset -> D issued first, I next cycle. Responses 0x100 then 0x200 -> each routed correctly despite the reversed order.
- D-cache write of 0x300 with wdata W -> mc_write=1 and mc_wdata=W, dcache_resp the next cycle. cl_ready low for 3 cycles -> I-cache read held off, then issued.
- Both clients read 0x400, I first -> the first cl_resp for 0x400 goes to I only; the second goes to D.
- cl_resp with raddr 0x999 matching nothing -> spurious_resp=1 for one cycle, no client resp.
- rst pulled low while I is PEND -> all outputs 0 immediately. The late cl_resp for that line -> spurious_resp, no icache_resp.
